vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Produces the raster timing that Game_Logic and every other pixel consumer draw against:
//   hcount, vcount, bright, plus hsync/vsync for the VGA connector.
//   Divides the system clock to a pixel-rate enable and runs the horizontal/vertical counters.
//   Emits a once-per-frame tick and a frame counter, used to time game phases such as the map-show timer.
// PARAMETERS
//   CLK_DIV   4    system clocks per pixel (100 MHz -> 25 MHz); >=2
//   H_SYNC    96   hsync pulse width, pixels
//   H_BP      48   horizontal back porch, pixels
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   V_SYNC    2    vsync pulse width, lines
//   V_BP      33   vertical back porch, lines
//   V_ACTIVE  480  visible lines
//   V_FP      10   vertical front porch, lines
//   (H_TOTAL = sum of H_* = 800, V_TOTAL = sum of V_* = 525; each total must be <= 1024)
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low reset (0 = in reset)
//   pix_en       out  1   one-clk strobe every CLK_DIV clks; counters advance on the edge that ends it
//   hcount       out  10  raw horizontal position, 0..H_TOTAL-1
//   vcount       out  10  raw vertical position, 0..V_TOTAL-1
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   bright       out  1   1 when (hcount,vcount) lies in the visible region
//   frame_start  out  1   one-clk pulse on the last pixel-enable of each frame
//   frame_count  out  16  frames completed since reset, wraps
// BEHAVIOUR
//   - Asynchronous reset (reset=0) clears div counter, hcount, vcount and frame_count to 0 immediately,
//     without a clock edge. Outputs: pix_en=0, frame_start=0, bright=0, hsync=0, vsync=0
//     (counter 0 lies in the sync region).
//   - div: 0..CLK_DIV-1, increments every clk and wraps to 0. pix_en = (div==CLK_DIV-1).
//     After reset is released, the first pix_en is high in the 4th clk (div==3).
//   - On a clk edge with pix_en=1: hcount+1. At H_TOTAL-1, hcount wraps to 0 and vcount+1 on the same edge.
//     At V_TOTAL-1, vcount wraps to 0 on the edge where hcount wraps. Counters never leave range.
//   - Decodes are functions of the registered counters only, with no skew between them:
//       hsync  = ~(hcount < H_SYNC)
//       vsync  = ~(vcount < V_SYNC)
//       bright = (HS <= hcount < HS+H_ACTIVE) && (VS <= vcount < VS+V_ACTIVE)
//     where HS = H_SYNC+H_BP = 144 and VS = V_SYNC+V_BP = 35.
//     Default visible window: hcount 144..783, vcount 35..514.
//   - frame_start = pix_en && hcount==H_TOTAL-1 && vcount==V_TOTAL-1.
//     frame_count increments on that same edge and wraps 0xFFFF -> 0.
//     No frame_start is issued at reset release.
//   - Timing: line = H_TOTAL*CLK_DIV = 3200 clks; frame = 800*525*4 = 1,680,000 clks.
//     hsync low 384 clks per line; vsync low 2 lines = 6400 clks.
//   - Reset asserted mid-frame aborts the frame. Counting restarts at (0,0) with frame_count=0
//     after release; no partial-frame pulse is produced.
//   - All state is held in registers; no combinational path from the reset input to the sync outputs
//     other than the asynchronous clear.
// TESTING
//   1. Release reset -> pix_en first high in clk 3; hcount 0->1 on that edge; hsync low for 384 clks,
//      then high.
//   2. Run to hcount=799, vcount=0 -> next pix_en edge gives hcount=0, vcount=1; hsync falls again
//      at hcount=0.
//   3. Sample bright -> 0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (144,515).
//   4. Run 2 full frames -> exactly one 1-clk frame_start per 1,680,000 clks; frame_count 0->1->2;
//      vsync low exactly 6400 clks per frame.
//   5. Assert reset asynchronously at (400,200), mid clk-period -> all outputs reach reset values
//      before the next edge; after release, counting restarts at (0,0).
//   6. Small timing (H_* = 2,1,4,1; V_* = 1,1,2,1; CLK_DIV=2), preload frame_count to 0xFFFE
//      -> after 2 frames frame_count=0x0000; bright window checked for the small timing.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, horizontal/vertical counters, sync/visible decodes,
// and a per-frame tick with a wrapping frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_en,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        bright,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // 11-bit bounds so a visible window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] H_VIS_START = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_VIS_START = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_VIS_END   = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       hcount_q;
    logic [9:0]       vcount_q;
    logic [15:0]      frame_count_q;
    logic             h_last;
    logic             v_last;

    assign pix_en      = (div_q == DIV_LAST);
    assign h_last      = (hcount_q == H_LAST);
    assign v_last      = (vcount_q == V_LAST);
    assign frame_start = pix_en && h_last && v_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (pix_en) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // vcount only moves on the edge where hcount wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcount_q <= '0;
                if (v_last) begin
                    vcount_q <= '0;
                end else begin
                    vcount_q <= vcount_q + 10'd1;
                end
            end else begin
                hcount_q <= hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_q <= '0;
        end else if (frame_start) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    // Decodes all come from the same registered counters, so they share one timing reference
    assign hsync  = ~({1'b0, hcount_q} < H_SYNC_END);
    assign vsync  = ~({1'b0, vcount_q} < V_SYNC_END);
    assign bright = ({1'b0, hcount_q} >= H_VIS_START) && ({1'b0, hcount_q} < H_VIS_END) &&
                    ({1'b0, vcount_q} >= V_VIS_START) && ({1'b0, vcount_q} < V_VIS_END);

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_count = frame_count_q;

endmodule
